// File: rtl/rvx_route_pkg.sv
// Shared routing types and helpers for the dispatch router.
// Default widths match the common 32-bit, 8-port configuration.
package rvx_route_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_NUM_OUTPUTS = 8;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SEL_WIDTH = sel_width(DEF_NUM_OUTPUTS);

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_SEL_WIDTH-1:0]  dest;
  } route_entry_t;

endpackage

// File: rtl/dispatch_router_demux.sv
// Utils demux: steers one data word to the selected lane.
// Every unselected lane is driven to zero.
module dispatch_router_demux
  import rvx_route_pkg::*;
#(
  parameter  int DataWidth  = DEF_DATA_WIDTH,
  parameter  int NumOutputs = DEF_NUM_OUTPUTS,
  localparam int SelWidth   = sel_width(NumOutputs)
) (
  input  logic [SelWidth-1:0]                  sel_i,
  input  logic [DataWidth-1:0]                 data_i,
  output logic [NumOutputs-1:0][DataWidth-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < NumOutputs; k++) begin
      if (sel_i == SelWidth'(k)) data_o[k] = data_i;
    end
  end

endmodule

// File: rtl/dispatch_router.sv
// Buffered in-order router: FIFO of (data, dest) words whose
// head is steered to exactly one of NumOutputs consumer ports.
module dispatch_router
  import rvx_route_pkg::*;
#(
  parameter  int DataWidth  = DEF_DATA_WIDTH,
  parameter  int NumOutputs = DEF_NUM_OUTPUTS,
  parameter  int Depth      = 2,
  localparam int SelWidth   = sel_width(NumOutputs),
  localparam int CntWidth   = $clog2(Depth) + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [DataWidth-1:0]                 in_data_i,
  input  logic [SelWidth-1:0]                  in_dest_i,
  output logic [NumOutputs-1:0]                out_valid_o,
  input  logic [NumOutputs-1:0]                out_ready_i,
  output logic [NumOutputs-1:0][DataWidth-1:0] out_data_o,
  output logic [CntWidth-1:0]                  count_o,
  output logic                                 drop_o,
  output logic                                 err_o
);

  localparam int PtrWidth = $clog2(Depth);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [SelWidth-1:0]  dest;
  } entry_t;

  entry_t              mem_q [Depth];
  entry_t              head;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                err_q, err_d;
  logic                empty, full;
  logic                push, pop, write, bad, in_range;
  logic [SelWidth-1:0]  dmx_sel;
  logic [DataWidth-1:0] dmx_data;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CntWidth'(Depth));
  assign in_ready_o = ~full & ~flush_i;
  assign push       = in_valid_i & in_ready_o;

  if ((1 << SelWidth) == NumOutputs) begin : g_range_full
    assign in_range = 1'b1;
  end else begin : g_range_part
    assign in_range = (in_dest_i < SelWidth'(NumOutputs));
  end

  assign write  = push & in_range;
  assign bad    = push & ~in_range;
  assign drop_o = bad & ~rst_i;

  assign head = mem_q[rd_ptr_q];

  // Valid is decoded here so that gating of data stays in the demux.
  always_comb begin
    out_valid_o = '0;
    for (int k = 0; k < NumOutputs; k++) begin
      if (!empty && head.dest == SelWidth'(k)) out_valid_o[k] = 1'b1;
    end
  end

  assign pop = (|(out_valid_o & out_ready_i)) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | bad;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (write) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({write, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write) mem_q[wr_ptr_q] <= '{data: in_data_i, dest: in_dest_i};
  end

  assign dmx_sel  = empty ? '0 : head.dest;
  assign dmx_data = empty ? '0 : head.data;

  dispatch_router_demux #(
    .DataWidth  (DataWidth),
    .NumOutputs (NumOutputs)
  ) u_demux (
    .sel_i  (dmx_sel),
    .data_i (dmx_data),
    .data_o (out_data_o)
  );

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dispatch_router.sv
// Directed bench for dispatch_router (8-port and 6-port builds).
module tb_dispatch_router;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [2:0]       in_dest;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [7:0][31:0] out_data;
  logic [1:0]       count;
  logic             drop;
  logic             err;

  logic             flush6;
  logic             in_valid6;
  logic             in_ready6;
  logic [31:0]      in_data6;
  logic [2:0]       in_dest6;
  logic [5:0]       out_valid6;
  logic [5:0]       out_ready6;
  logic [5:0][31:0] out_data6;
  logic [1:0]       count6;
  logic             drop6;
  logic             err6;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0][31:0] exp8;
  logic [5:0][31:0] exp6;

  always #5 clk = ~clk;

  dispatch_router #(.DataWidth(32), .NumOutputs(8), .Depth(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_dest_i   (in_dest),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .count_o     (count),
    .drop_o      (drop),
    .err_o       (err)
  );

  dispatch_router #(.DataWidth(32), .NumOutputs(6), .Depth(2)) dut6 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush6),
    .in_valid_i  (in_valid6),
    .in_ready_o  (in_ready6),
    .in_data_i   (in_data6),
    .in_dest_i   (in_dest6),
    .out_valid_o (out_valid6),
    .out_ready_i (out_ready6),
    .out_data_o  (out_data6),
    .count_o     (count6),
    .drop_o      (drop6),
    .err_o       (err6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
    in_dest = 3'd3; in_data = 32'h55; out_ready = '1;
    flush6 = 1'b0; in_valid6 = 1'b0; in_data6 = '0;
    in_dest6 = '0; out_ready6 = '0;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 8'h00) begin
      n_bad++; $display("FAIL rst_valid got %h want 00", out_valid);
    end
    n_cmp++;
    if (count !== 2'd0) begin
      n_bad++; $display("FAIL rst_count got %0d want 0", count);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL rst_err got %b want 0", err);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready got %b want 1", in_ready);
    end
    n_cmp++;
    if (out_data !== '0) begin
      n_bad++; $display("FAIL rst_data got %h want 0", out_data);
    end
  endtask

  task automatic test_streaming();
    out_ready = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      in_data  = 32'hA0 + 32'(i);
      in_dest  = 3'(i);
      #1;
      if (i == 0) begin
        n_cmp++;
        if (count !== 2'd0) begin
          n_bad++; $display("FAIL stream_cnt0 got %0d want 0", count);
        end
      end else begin
        exp8 = '0;
        exp8[i-1] = 32'hA0 + 32'(i - 1);
        n_cmp++;
        if (out_valid !== 8'(1 << (i - 1))) begin
          n_bad++;
          $display("FAIL stream_valid%0d got %h want %h",
                   i - 1, out_valid, 8'(1 << (i - 1)));
        end
        n_cmp++;
        if (out_data !== exp8) begin
          n_bad++;
          $display("FAIL stream_data%0d got %h want %h",
                   i - 1, out_data, exp8);
        end
        n_cmp++;
        if (count !== 2'd1) begin
          n_bad++; $display("FAIL stream_cnt%0d got %0d want 1",
                            i - 1, count);
        end
      end
      tick();
    end
    n_cmp++;
    if (count !== 2'd0 || out_valid !== 8'h00) begin
      n_bad++; $display("FAIL stream_end got cnt %0d vld %h want 0 00",
                        count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 8'h00;
    in_valid = 1'b1; in_data = 32'h11; in_dest = 3'd2;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_ready0 got %b want 1", in_ready);
    end
    tick();
    in_data = 32'h22; in_dest = 3'd5;
    #1;
    n_cmp++;
    if (count !== 2'd1 || out_valid !== 8'h04) begin
      n_bad++; $display("FAIL bp_one got cnt %0d vld %h want 1 04",
                        count, out_valid);
    end
    tick();
    in_data = 32'h33; in_dest = 3'd2;
    #1;
    n_cmp++;
    if (count !== 2'd2 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_full got cnt %0d rdy %b want 2 0",
                        count, in_ready);
    end
    n_cmp++;
    if (out_data[2] !== 32'h11) begin
      n_bad++; $display("FAIL bp_head got %h want 11", out_data[2]);
    end
    tick();
    out_ready = 8'h20;
    #1;
    n_cmp++;
    if (out_valid !== 8'h04 || count !== 2'd2) begin
      n_bad++; $display("FAIL bp_hold got vld %h cnt %0d want 04 2",
                        out_valid, count);
    end
    tick();
    n_cmp++;
    if (count !== 2'd2 || out_data[2] !== 32'h11) begin
      n_bad++; $display("FAIL bp_nopop got cnt %0d dat %h want 2 11",
                        count, out_data[2]);
    end
    out_ready = 8'h24;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_popfull got rdy %b want 0", in_ready);
    end
    tick();
    n_cmp++;
    if (count !== 2'd1 || out_valid !== 8'h20 || out_data[5] !== 32'h22) begin
      n_bad++;
      $display("FAIL bp_pop1 got cnt %0d vld %h dat %h want 1 20 22",
               count, out_valid, out_data[5]);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== 2'd1 || out_valid !== 8'h04 || out_data[2] !== 32'h33) begin
      n_bad++;
      $display("FAIL bp_pop2 got cnt %0d vld %h dat %h want 1 04 33",
               count, out_valid, out_data[2]);
    end
    tick();
    n_cmp++;
    if (count !== 2'd0) begin
      n_bad++; $display("FAIL bp_drain got %0d want 0", count);
    end
    out_ready = 8'h00;
  endtask

  task automatic test_back_to_back();
    out_ready = 8'h00;
    in_valid = 1'b1; in_data = 32'hB0; in_dest = 3'd0;
    tick();
    out_ready = 8'hFF;
    for (int it = 1; it <= 10; it++) begin
      in_data = 32'hB0 + 32'(it);
      in_dest = 3'(it % 8);
      #1;
      exp8 = '0;
      exp8[(it - 1) % 8] = 32'hB0 + 32'(it - 1);
      n_cmp++;
      if (count !== 2'd1 || out_data !== exp8 ||
          out_valid !== 8'(1 << ((it - 1) % 8))) begin
        n_bad++;
        $display("FAIL b2b_%0d got cnt %0d vld %h dat %h want 1 %h %h",
                 it, count, out_valid, out_data,
                 8'(1 << ((it - 1) % 8)), exp8);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (count !== 2'd1 || out_valid !== 8'h04 || out_data[2] !== 32'hBA) begin
      n_bad++;
      $display("FAIL b2b_last got cnt %0d vld %h dat %h want 1 04 ba",
               count, out_valid, out_data[2]);
    end
    tick();
    out_ready = 8'h00;
  endtask

  task automatic test_out_of_range();
    out_ready6 = 6'h00;
    in_valid6 = 1'b1; in_data6 = 32'hDEAD; in_dest6 = 3'd7;
    #1;
    n_cmp++;
    if (drop6 !== 1'b1 || in_ready6 !== 1'b1) begin
      n_bad++; $display("FAIL oor_drop got drop %b rdy %b want 1 1",
                        drop6, in_ready6);
    end
    tick();
    in_valid6 = 1'b0;
    #1;
    n_cmp++;
    if (drop6 !== 1'b0 || err6 !== 1'b1) begin
      n_bad++; $display("FAIL oor_pulse got drop %b err %b want 0 1",
                        drop6, err6);
    end
    n_cmp++;
    if (count6 !== 2'd0 || out_valid6 !== 6'h00) begin
      n_bad++; $display("FAIL oor_nowrite got cnt %0d vld %h want 0 00",
                        count6, out_valid6);
    end
    tick();
    in_valid6 = 1'b1; in_data6 = 32'h44; in_dest6 = 3'd4;
    #1;
    n_cmp++;
    if (err6 !== 1'b1 || drop6 !== 1'b0) begin
      n_bad++; $display("FAIL oor_sticky got err %b drop %b want 1 0",
                        err6, drop6);
    end
    tick();
    in_valid6 = 1'b0;
    #1;
    exp6 = '0;
    exp6[4] = 32'h44;
    n_cmp++;
    if (out_valid6 !== 6'h10 || out_data6 !== exp6 || count6 !== 2'd1) begin
      n_bad++;
      $display("FAIL oor_route got vld %h dat %h cnt %0d want 10 %h 1",
               out_valid6, out_data6, count6, exp6);
    end
  endtask

  task automatic test_flush();
    in_valid6 = 1'b1; in_data6 = 32'h55; in_dest6 = 3'd1;
    tick();
    flush6 = 1'b1; in_data6 = 32'h66; in_dest6 = 3'd0;
    out_ready6 = 6'h10;
    #1;
    n_cmp++;
    if (count6 !== 2'd2 || in_ready6 !== 1'b0) begin
      n_bad++; $display("FAIL fl_cycle got cnt %0d rdy %b want 2 0",
                        count6, in_ready6);
    end
    n_cmp++;
    if (out_valid6 !== 6'h10) begin
      n_bad++; $display("FAIL fl_keepvld got %h want 10", out_valid6);
    end
    tick();
    flush6 = 1'b0; in_valid6 = 1'b0;
    #1;
    n_cmp++;
    if (count6 !== 2'd0 || out_valid6 !== 6'h00 || out_data6 !== '0) begin
      n_bad++;
      $display("FAIL fl_after got cnt %0d vld %h dat %h want 0 00 0",
               count6, out_valid6, out_data6);
    end
    n_cmp++;
    if (err6 !== 1'b1 || in_ready6 !== 1'b1) begin
      n_bad++; $display("FAIL fl_err got err %b rdy %b want 1 1",
                        err6, in_ready6);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatch_router.md
Name: dispatch_router

Overview:
- Buffered valid/ready router that sits directly upstream of the utils demux.
- Accepts a single stream of (data, destination index) words, queues them in a small in-order FIFO, and steers the head word to exactly one of NumOutputs consumer ports through the demux.
- Used wherever one producer (decode/issue, bus response) feeds N functional-unit or register-bank queues.

Parameters:
- DataWidth, 32, payload width in bits.
- NumOutputs, 8, number of destination ports (>=1).
- Depth, 2, FIFO entries; power of two, >=2.
- SelWidth (localparam), $clog2(NumOutputs), or 1 when that is 0; destination index width.
- CntWidth (localparam), $clog2(Depth)+1, occupancy counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous queue clear.
- in_valid_i  in  1  producer word valid.
- in_ready_o  out  1  router can accept this cycle.
- in_data_i  in  DataWidth  payload.
- in_dest_i  in  SelWidth  destination index.
- out_valid_o  out  NumOutputs  one-hot (or zero) valid per destination.
- out_ready_i  in  NumOutputs  per-destination ready.
- out_data_o  out  [NumOutputs][DataWidth]  head payload on the selected port; all other ports '0.
- count_o  out  CntWidth  current FIFO occupancy.
- drop_o  out  1  one-cycle pulse: accepted word had an out-of-range destination and was discarded.
- err_o  out  1  sticky drop flag.

Behaviour:
- Interface: one clock, clk_i; rst_i is synchronous and active-high.
- Reset (rst_i=1 at an edge):
  - rd/wr pointers and count cleared.
  - out_valid_o='0, out_data_o all '0, count_o=0, drop_o=0, err_o=0.
  - in_ready_o=1 from the first cycle after reset.
  - rst_i has priority over every other input. Reset mid-transfer discards all queued words; no output handshake completes in that cycle.
- Handshakes:
  - in_ready_o = (count != Depth) & ~flush_i. It is registered-state based and has no combinational path from out_ready_i.
  - Push when in_valid_i & in_ready_o.
  - out_valid_o[k] = (count != 0) & (head.dest == k); never more than one bit set.
  - Pop when out_valid_o[k] & out_ready_i[k] for the selected k. out_ready_i of unselected ports is ignored.
  - Once asserted, a valid output and its data stay stable until popped, flushed or reset.
- Latency:
  - Word accepted at edge N appears on its out port in cycle N+1 at the earliest (registered storage, no bypass).
  - Throughput is one word per cycle when count is between 0 and Depth and the consumer is ready.
- Ordering: strict FIFO order across all destinations. A stalled head blocks later words even if those target a ready port (no reordering).
- Simultaneous push and pop: count unchanged, both pointers advance. When full, push is blocked even if a pop occurs the same cycle.
- Pointers: log2(Depth)-bit wrap-around. Full/empty are derived from count.
- Out-of-range destination (in_dest_i >= NumOutputs, only possible for non-power-of-two NumOutputs):
  - The word is accepted (handshake completes) but not written.
  - drop_o=1 for that cycle; err_o sets and holds until rst_i.
- flush_i:
  - Next state is empty; pointers go to 0.
  - Any push in the same cycle is blocked (in_ready_o=0).
  - out_valid_o stays as-is during the flush cycle, but no pop is recorded; outputs are '0 the next cycle. err_o is unaffected.
- Data path: head entry data and dest drive the demux data input and select. The demux forces unselected data lanes to '0. When empty, the select is 0 and the data lane is gated to '0.

Decomposition:
- Shared package rvx_route_pkg:
  - route_entry_t struct {data, dest}, parameterised through a width-generic typedef or package constants DEF_DATA_WIDTH=32, DEF_NUM_OUTPUTS=8.
  - Function sel_width(n) returning $clog2(n), or 1 when that is 0.
- Sub-module: instantiates the existing utils demux (DataWidth, NumOutputs) for out_data_o.
- Valid one-hot is generated locally, not through the demux, so valid and data share the select but not the gating.

Test Plan:
- Reset: hold rst_i 2 cycles with in_valid_i=1, dest=3 -> out_valid_o=0, count_o=0, err_o=0, in_ready_o=1 on the first post-reset cycle.
- Streaming: push 0xA0..0xA7 to dests 0..7 back-to-back, all ready=1 -> each word appears on port k exactly one cycle after accept, in order, other lanes '0, count_o never exceeds 1.
- Backpressure/full: push 0x11 (dest 2), 0x22 (dest 5), 0x33 (dest 2) with out_ready_i=0 -> count_o=2, in_ready_o=0, 0x33 held off. Then raise ready[5] only -> nothing pops (head targets port 2). Raise ready[2] -> 0x11 pops, then 0x22 pops, then 0x33 is accepted.
- Simultaneous push/pop at count=1 -> count stays 1; pointer wraps correctly over 10 iterations with data intact.
- NumOutputs=6: push dest 7 with data 0xDEAD -> drop_o pulses 1 cycle, err_o stays 1, count_o unchanged, no out_valid_o. Then dest 4 routes normally.
- Flush with 2 queued words and in_valid_i=1 -> in_ready_o=0 that cycle, count_o=0 and out_valid_o='0 the next cycle, err_o preserved.
